seq_multiplier: RTL
===================

// Module: seq_multiplier
// PURPOSE
//   Unsigned shift-and-add multiplier: WIDTH x WIDTH -> 2*WIDTH product, one partial product per clock.
//   Consumer stage of the shared component library; its datapath is built from Adder, Register, counter.
//   Sits between operand-producing logic (start/A/B) and a result consumer (done/product).
// PARAMETERS
//   WIDTH  8  operand width in bits; product is 2*WIDTH bits; WIDTH >= 2
// PORTS
//   clock    in   1          system clock, all state updates on posedge
//   clear    in   1          reset: synchronous, active-high; priority over every other input
//   start    in   1          request; sampled only while ready=1
//   A        in   WIDTH      multiplicand, captured on the accepted start cycle
//   B        in   WIDTH      multiplier, captured on the accepted start cycle
//   ready    out  1          1 in IDLE: new start will be accepted
//   done     out  1          one-cycle pulse: product is valid
//   product  out  2*WIDTH    result; holds its value from done until the next accepted start
// BEHAVIOUR
//   Reset (clear=1 at posedge): state=IDLE, ready=1, done=0, product=0, internal regs=0.
//   States: IDLE -> CALC -> DONE -> IDLE.
//   IDLE: ready=1. start=1 -> load mcand={WIDTH'0,A}, mplier=B, acc=0, count=0; go CALC.
//         start=0 -> stay; product held.
//   CALC: ready=0. Each cycle: if mplier[0] acc <= acc + mcand; mcand <= mcand<<1;
//         mplier <= mplier>>1; count <= count+1. Exit to DONE when count==WIDTH-1.
//   DONE: ready=0, done=1 for exactly one cycle; product=acc; next state IDLE unconditionally.
//   Latency: start accepted at edge 0 -> CALC on cycles 1..WIDTH -> done=1 on cycle WIDTH+1;
//     ready=1 again on cycle WIDTH+2; back-to-back start accepted on that cycle.
//   Arithmetic: 2*WIDTH-bit accumulate, no overflow possible (max (2^W-1)^2 < 2^(2W)); Adder Cin=0, Cout unused.
//   start while ready=0: ignored, no queueing; A/B changes after capture have no effect.
//   clear mid-CALC or in DONE: IDLE next cycle, done never pulses, product=0.
//   clear and start same cycle: clear wins, operation not accepted.
//   product only updates in DONE; during CALC it shows previous result (0 after reset).
// CONFIGURATION
//   MULT_EARLY_EXIT_EN defined: CALC also exits to DONE when mplier[WIDTH-1:1]==0 (no set bits
//     remain after the current step). CALC length = max(1, index of highest set bit of B + 1);
//     B=0 or B=1 -> 1 CALC cycle, done on cycle 2. Results identical to the macro-off build.
//   Not defined: CALC always lasts exactly WIDTH cycles, independent of operand values.
// STRUCTURE
//   Package mult_pkg: state_t enum {IDLE, CALC, DONE}; localparam for count width $clog2(WIDTH).
//   Sub-module mult_fsm: state register + next-state/output logic; inputs start, clear, last_iter;
//     outputs ready, done, load, step. Datapath (mcand/mplier shift regs, acc Register, Adder,
//     iteration counter) lives in seq_multiplier.
// TESTING  (WIDTH=8; cycle numbers relative to accepted start edge = 0)
//   1. clear=1 two cycles then idle -> ready=1, done=0, product=16'h0000; start ignored while clear=1.
//   2. A=13, B=11, start (macro off) -> done=1 on cycle 9 only, product=143, ready=1 on cycle 10.
//   3. A=255, B=255 -> product=16'hFE01 (65025); then A=0, B=200 -> product=0; back-to-back starts.
//   4. A=6, B=7 start; at cycle 3 start=1 with A=9,B=9 -> ignored, done cycle 9, product=42.
//   5. A=13, B=11 start; clear=1 at cycle 4 -> cycle 5 ready=1, product=0, no done pulse ever.
//   6. MULT_EARLY_EXIT_EN: A=200, B=3 -> done cycle 3, product=600; B=0 -> done cycle 2, product=0.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared types and sizing helpers for the sequential shift-and-add multiplier.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned DEFAULT_WIDTH = 8;
  localparam int unsigned DEFAULT_CNT_W = $clog2(DEFAULT_WIDTH);

  // Iteration counter width; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/mult_fsm.sv
// Control FSM for seq_multiplier: IDLE -> CALC -> DONE -> IDLE with registered ready/done.
module mult_fsm
  import mult_pkg::*;
(
  input  logic clock,
  input  logic clear,
  input  logic start,
  input  logic last_iter,
  output logic ready,
  output logic done,
  output logic load,
  output logic step
);

  state_t state_q;
  logic   ready_q;
  logic   done_q;

  // State register with registered ready/done outputs; clear has top priority.
  always_ff @(posedge clock) begin
    if (clear) begin
      state_q <= IDLE;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            state_q <= CALC;
            ready_q <= 1'b0;
          end else begin
            ready_q <= 1'b1;
          end
        end
        CALC: begin
          ready_q <= 1'b0;
          if (last_iter) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else begin
            done_q  <= 1'b0;
          end
        end
        DONE: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign ready = ready_q;
  assign done  = done_q;
  assign load  = ready_q & start;
  assign step  = (state_q == CALC);

endmodule

// File: rtl/seq_multiplier.sv
// Unsigned WIDTH x WIDTH shift-and-add multiplier, one partial product per clock.
// Optional MULT_EARLY_EXIT_EN ends CALC once no multiplier bits remain set.
module seq_multiplier
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic                 clock,
  input  logic                 clear,
  input  logic                 start,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic                 ready,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int unsigned CNT_W = cnt_width(WIDTH);

  logic [2*WIDTH-1:0] mcand_q,   mcand_d;
  logic [WIDTH-1:0]   mplier_q,  mplier_d;
  logic [2*WIDTH-1:0] acc_q,     acc_d;
  logic [CNT_W-1:0]   count_q,   count_d;
  logic [2*WIDTH-1:0] product_q, product_d;
  logic [2*WIDTH-1:0] sum_s;
  logic               load_s;
  logic               step_s;
  logic               last_iter_s;

  mult_fsm u_fsm (
    .clock     (clock),
    .clear     (clear),
    .start     (start),
    .last_iter (last_iter_s),
    .ready     (ready),
    .done      (done),
    .load      (load_s),
    .step      (step_s)
  );

  // Full-width accumulate: the product of two WIDTH-bit values cannot overflow 2*WIDTH bits.
  assign sum_s = acc_q + (mplier_q[0] ? mcand_q : {(2*WIDTH){1'b0}});

`ifdef MULT_EARLY_EXIT_EN
  assign last_iter_s = (count_q == CNT_W'(WIDTH-1)) ||
                       (mplier_q[WIDTH-1:1] == {(WIDTH-1){1'b0}});
`else
  assign last_iter_s = (count_q == CNT_W'(WIDTH-1));
`endif

  // Datapath next-state: operand capture, one shift/add per CALC cycle, result latch on the last step.
  always_comb begin
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    count_d   = count_q;
    product_d = product_q;
    if (load_s) begin
      mcand_d  = {{WIDTH{1'b0}}, A};
      mplier_d = B;
      acc_d    = {(2*WIDTH){1'b0}};
      count_d  = {CNT_W{1'b0}};
    end else if (step_s) begin
      acc_d    = sum_s;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      count_d  = count_q + CNT_W'(1);
      if (last_iter_s) begin
        product_d = sum_s;
      end else begin
        product_d = product_q;
      end
    end else begin
      product_d = product_q;
    end
  end

  // Datapath registers.
  always_ff @(posedge clock) begin
    if (clear) begin
      mcand_q   <= {(2*WIDTH){1'b0}};
      mplier_q  <= {WIDTH{1'b0}};
      acc_q     <= {(2*WIDTH){1'b0}};
      count_q   <= {CNT_W{1'b0}};
      product_q <= {(2*WIDTH){1'b0}};
    end else begin
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      count_q   <= count_d;
      product_q <= product_d;
    end
  end

  assign product = product_q;

endmodule
